l2_bus_tx_q: RTL

// Parametrised L2 bus transmitter between l2data/l2tag and the slotted shared bus.
// - Queues one miss/upgrade/writeback request and up to SNOOP_DEPTH snoop-flush responses, each with a full line buffer.
// - Arbitrates for the bus and drives the command slot; retries nacked requests.
// - Allocates request tags under a credit limit; promotes BUSUPGR to BUSRDX on address conflict.

---
 rtl/l2_bus_tx_q_if.sv | 59 +++++
 rtl/l2_bus_tx_q.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/l2_bus_tx_q_if.sv
// Bundle of l2data/l2tag/bus signals seen by the L2 bus transmitter.
//   master : view used by l2_bus_tx_q (drives the bus command slot)
//   slave  : view used by the surrounding logic (l2data, l2tag, bus fabric)
// Groups: req_* request beats in, snp_* snoop-flush beats in, done_* completion
// out, retire_valid credit return in, bus_* arbitration and slot signals.
interface l2_bus_tx_q_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned TAG_W  = 3
);
  logic              req_valid;
  logic [2:0]        req_cmd;
  logic [25:0]       req_addr;
  logic [DATA_W-1:0] req_data;
  logic              req_ready;

  logic              snp_valid;
  logic [4:0]        snp_tag;
  logic [25:0]       snp_addr;
  logic [DATA_W-1:0] snp_data;
  logic              snp_ready;

  logic              done_valid;
  logic [TAG_W-1:0]  done_tag;
  logic              retire_valid;

  logic              bus_req;
  logic              bus_grant;
  logic [2:0]        bus_cmd_o;
  logic [4:0]        bus_tag_o;
  logic [25:0]       bus_addr_o;
  logic [DATA_W-1:0] bus_data_o;
  logic              bus_valid;
  logic              bus_nack;
  logic [2:0]        bus_cmd;
  logic [4:0]        bus_tag;
  logic [25:0]       bus_addr;

  modport master (
    input  req_valid, req_cmd, req_addr, req_data,
    output req_ready,
    input  snp_valid, snp_tag, snp_addr, snp_data,
    output snp_ready,
    output done_valid, done_tag,
    input  retire_valid,
    output bus_req, bus_cmd_o, bus_tag_o, bus_addr_o, bus_data_o,
    input  bus_grant, bus_valid, bus_nack, bus_cmd, bus_tag, bus_addr
  );

  modport slave (
    output req_valid, req_cmd, req_addr, req_data,
    input  req_ready,
    output snp_valid, snp_tag, snp_addr, snp_data,
    input  snp_ready,
    input  done_valid, done_tag,
    output retire_valid,
    input  bus_req, bus_cmd_o, bus_tag_o, bus_addr_o, bus_data_o,
    output bus_grant, bus_valid, bus_nack, bus_cmd, bus_tag, bus_addr
  );
endinterface

// File: rtl/l2_bus_tx_q.sv
// L2 bus transmitter: buffers one miss/upgrade/writeback request and up to
// SNOOP_DEPTH snoop-flush lines, arbitrates for the slotted shared bus and
// drives the command slot it wins. Nacked requests are retried; request tags
// are allocated under a credit limit returned by l2tag.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : l2_bus_tx_q_if.master (request/snoop fill, completion, credit
//              return, bus request/grant, driven slot, observed slot)
// Bus command encoding: 0 none, 1 BUSRD, 2 BUSRDX, 3 BUSUPGR, 4 FLUSH.
module l2_bus_tx_q #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned BEATS       = 8,
  parameter int unsigned TAG_W       = 3,
  parameter int unsigned SNOOP_DEPTH = 2,
  parameter logic [1:0]  BUS_ID      = 2'd1
) (
  input  logic           clk,
  input  logic           rst,
  l2_bus_tx_q_if.master  bus
);
  localparam logic [2:0] CMD_NONE    = 3'd0;
  localparam logic [2:0] CMD_BUSRD   = 3'd1;
  localparam logic [2:0] CMD_BUSRDX  = 3'd2;
  localparam logic [2:0] CMD_BUSUPGR = 3'd3;
  localparam logic [2:0] CMD_FLUSH   = 3'd4;

  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam int unsigned PTR_W = (SNOOP_DEPTH > 1) ? $clog2(SNOOP_DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(SNOOP_DEPTH + 1);

  localparam int unsigned LAST_I  = BEATS - 1;
  localparam int unsigned DLAST_I = SNOOP_DEPTH - 1;
  localparam int unsigned DEPTH_I = SNOOP_DEPTH;
  localparam int unsigned CRED_I  = 1 << TAG_W;
  localparam logic [CNT_W-1:0] SLOT_LAST = LAST_I[CNT_W-1:0];
  localparam logic [PTR_W-1:0] PTR_LAST  = DLAST_I[PTR_W-1:0];
  localparam logic [OCC_W-1:0] OCC_FULL  = DEPTH_I[OCC_W-1:0];
  localparam logic [TAG_W:0]   CRED_MAX  = CRED_I[TAG_W:0];

  typedef enum logic [1:0] {REQ_EMPTY, REQ_FILL, REQ_FULL} req_state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_REQ, OWN_SNP} own_e;

  logic [CNT_W-1:0]  slot_cnt;
  logic [CNT_W-1:0]  nxt_idx;
  logic              slot_last;

  req_state_e        req_state;
  logic [2:0]        req_cmd_q;
  logic [25:0]       req_addr_q;
  logic [CNT_W-1:0]  req_idx;
  logic [DATA_W-1:0] req_line [BEATS];

  logic [4:0]        snp_tag_q  [SNOOP_DEPTH];
  logic [25:0]       snp_addr_q [SNOOP_DEPTH];
  logic [DATA_W-1:0] snp_line   [SNOOP_DEPTH][BEATS];
  logic [PTR_W-1:0]  snp_wr, snp_rd;
  logic [OCC_W-1:0]  snp_cnt;
  logic [CNT_W-1:0]  snp_idx;

  logic [TAG_W-1:0]  tag_ctr;
  logic [TAG_W:0]    credits;
  own_e              own, own_nxt;

  logic              done_valid_q;
  logic [TAG_W-1:0]  done_tag_q;
  logic [2:0]        bus_cmd_q, cmd_nxt;
  logic [4:0]        bus_tag_q, tag_nxt;
  logic [25:0]       bus_addr_q, addr_nxt;
  logic [DATA_W-1:0] bus_data_q, data_nxt;

  logic req_ready, snp_ready, req_acc, snp_acc, snp_push, snp_pop;
  logic req_elig, snp_elig, win_req, win_snp, req_done, upgr_hit;
  logic credit_inc;
  logic [2:0] req_cmd_eff;

  assign slot_last = (slot_cnt == SLOT_LAST);
  assign nxt_idx   = slot_cnt + 1'b1;

  assign req_ready = (req_state != REQ_FULL);
  assign snp_ready = (snp_cnt != OCC_FULL);
  assign req_acc   = bus.req_valid && req_ready;
  assign snp_acc   = bus.snp_valid && snp_ready;
  assign snp_push  = snp_acc && (snp_idx == SLOT_LAST);
  assign snp_pop   = slot_last && (own == OWN_SNP);

  // A source that owns the current slot does not compete for the next one;
  // a nacked request therefore re-arbitrates one slot later.
  assign req_elig  = (req_state == REQ_FULL) && (credits != '0) && (own != OWN_REQ);
  assign snp_elig  = (snp_cnt != '0) && (own != OWN_SNP);
  assign win_snp   = slot_last && bus.bus_grant && snp_elig;
  assign win_req   = slot_last && bus.bus_grant && !snp_elig && req_elig;
  assign req_done  = slot_last && (own == OWN_REQ) && !bus.bus_nack;
  assign credit_inc = bus.retire_valid && (credits != CRED_MAX);

  // Another unit's unnacked upgrade/read-exclusive to our line invalidates our
  // copy, so a pending upgrade must fetch the line instead.
  assign upgr_hit = (req_state == REQ_FULL) && (req_cmd_q == CMD_BUSUPGR) &&
                    (own != OWN_REQ) && bus.bus_valid && !bus.bus_nack &&
                    (bus.bus_addr == req_addr_q) &&
                    ((bus.bus_cmd == CMD_BUSUPGR) || (bus.bus_cmd == CMD_BUSRDX)) &&
                    (bus.bus_tag[4:3] != BUS_ID);
  assign req_cmd_eff = upgr_hit ? CMD_BUSRDX : req_cmd_q;

  // Slot outputs are registered: the data register is loaded one cycle
  // ahead with the beat for the upcoming slot position.
  always_comb begin
    own_nxt  = own;
    cmd_nxt  = bus_cmd_q;
    tag_nxt  = bus_tag_q;
    addr_nxt = bus_addr_q;
    if (slot_last) begin
      own_nxt  = OWN_NONE;
      cmd_nxt  = CMD_NONE;
      tag_nxt  = '0;
      addr_nxt = '0;
      if (win_snp) begin
        own_nxt  = OWN_SNP;
        cmd_nxt  = CMD_FLUSH;
        tag_nxt  = snp_tag_q[snp_rd];
        addr_nxt = snp_addr_q[snp_rd];
      end else if (win_req) begin
        own_nxt  = OWN_REQ;
        cmd_nxt  = req_cmd_eff;
        tag_nxt  = {BUS_ID, 3'(tag_ctr)};
        addr_nxt = req_addr_q;
      end
    end
    data_nxt = '0;
    if (cmd_nxt == CMD_FLUSH) begin
      if (own_nxt == OWN_SNP) data_nxt = snp_line[snp_rd][nxt_idx];
      else if (own_nxt == OWN_REQ) data_nxt = req_line[nxt_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt     <= '0;
      req_state    <= REQ_EMPTY;
      req_cmd_q    <= CMD_NONE;
      req_addr_q   <= '0;
      req_idx      <= '0;
      snp_wr       <= '0;
      snp_rd       <= '0;
      snp_cnt      <= '0;
      snp_idx      <= '0;
      tag_ctr      <= '0;
      credits      <= CRED_MAX;
      own          <= OWN_NONE;
      done_valid_q <= 1'b0;
      done_tag_q   <= '0;
      bus_cmd_q    <= CMD_NONE;
      bus_tag_q    <= '0;
      bus_addr_q   <= '0;
      bus_data_q   <= '0;
    end else begin
      slot_cnt <= nxt_idx;

      case (req_state)
        REQ_EMPTY: begin
          if (bus.req_valid) begin
            req_cmd_q  <= bus.req_cmd;
            req_addr_q <= bus.req_addr;
            if (bus.req_cmd == CMD_FLUSH) begin
              req_idx   <= req_idx + 1'b1;
              req_state <= REQ_FILL;
            end else begin
              req_state <= REQ_FULL;
            end
          end
        end
        REQ_FILL: begin
          if (bus.req_valid) begin
            req_idx <= req_idx + 1'b1;
            if (req_idx == SLOT_LAST) req_state <= REQ_FULL;
          end
        end
        REQ_FULL: begin
          if (req_done) req_state <= REQ_EMPTY;
          else if (upgr_hit) req_cmd_q <= CMD_BUSRDX;
        end
        default: req_state <= REQ_EMPTY;
      endcase

      if (snp_acc) snp_idx <= snp_idx + 1'b1;
      if (snp_push) snp_wr <= (snp_wr == PTR_LAST) ? '0 : snp_wr + 1'b1;
      if (snp_pop)  snp_rd <= (snp_rd == PTR_LAST) ? '0 : snp_rd + 1'b1;
      if (snp_push && !snp_pop) snp_cnt <= snp_cnt + 1'b1;
      else if (snp_pop && !snp_push) snp_cnt <= snp_cnt - 1'b1;

      done_valid_q <= req_done;
      if (req_done) begin
        done_tag_q <= tag_ctr;
        tag_ctr    <= tag_ctr + 1'b1;
      end
      if (req_done && !bus.retire_valid) credits <= credits - 1'b1;
      else if (credit_inc && !req_done) credits <= credits + 1'b1;

      own        <= own_nxt;
      bus_cmd_q  <= cmd_nxt;
      bus_tag_q  <= tag_nxt;
      bus_addr_q <= addr_nxt;
      bus_data_q <= data_nxt;
    end
  end

  // Line storage needs no reset: validity is tracked by the state above.
  always_ff @(posedge clk) begin
    if (req_acc) req_line[req_idx] <= bus.req_data;
    if (snp_acc) begin
      snp_line[snp_wr][snp_idx] <= bus.snp_data;
      if (snp_idx == '0) begin
        snp_tag_q[snp_wr]  <= bus.snp_tag;
        snp_addr_q[snp_wr] <= bus.snp_addr;
      end
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.snp_ready  = snp_ready;
  assign bus.done_valid = done_valid_q;
  assign bus.done_tag   = done_tag_q;
  assign bus.bus_req    = req_elig || snp_elig;
  assign bus.bus_cmd_o  = bus_cmd_q;
  assign bus.bus_tag_o  = bus_tag_q;
  assign bus.bus_addr_o = bus_addr_q;
  assign bus.bus_data_o = bus_data_q;
endmodule
